// File: rtl/alu16_result_queue_pkg.sv
// -----------------------------------------------------------------------------
// alu16_result_queue_pkg
//   Definitions shared by the 16-bit ALU and its result queue: opcode
//   constants, the layout of one queued result entry and a helper that builds
//   an entry (including the derived zero/negative flags) from raw ALU outputs.
//
//   Configuration macro: ALU16_RQ_PARITY_EN
//     defined   -> each entry carries an even-parity bit over yout
//     undefined -> no parity storage
// -----------------------------------------------------------------------------
package alu16_result_queue_pkg;

    // Opcode range of the ALU; the queue stores opcodes opaquely.
    localparam logic [3:0] ALU_OP_ADD = 4'h0;
    localparam logic [3:0] ALU_OP_MUL = 4'hF;

    // One queued result. Packed MSB-first, so yout sits in bits [15:0],
    // carry at 16, zero at 17, neg at 18, op at [22:19] and, when enabled,
    // parity at 23.
    typedef struct packed {
`ifdef ALU16_RQ_PARITY_EN
        logic        par;
`endif
        logic [3:0]  op;
        logic        neg;
        logic        zero;
        logic        carry;
        logic [15:0] yout;
    } rq_entry_t;

    localparam int ENTRY_W = $bits(rq_entry_t);

    // Flags are derived once at capture so the read side is pure storage.
    function automatic rq_entry_t make_entry(
        input logic [15:0] yout,
        input logic        carry,
        input logic [3:0]  op
    );
        rq_entry_t e;
        e.yout  = yout;
        e.carry = carry;
        e.zero  = (yout == 16'h0000);
        e.neg   = yout[15];
        e.op    = op;
`ifdef ALU16_RQ_PARITY_EN
        e.par   = ^yout;
`endif
        return e;
    endfunction

endpackage

// File: rtl/alu16_rq_mem.sv
// -----------------------------------------------------------------------------
// alu16_rq_mem
//   DEPTH x W register array backing the result queue.
//   Synchronous write, asynchronous (combinational) read, storage not reset.
//
//   Ports
//     clk      in   1      write clock
//     wr_en    in   1      write enable
//     wr_addr  in   AW     write address
//     wr_data  in   W      write data
//     rd_addr  in   AW     read address
//     rd_data  out  W      read data, combinational from rd_addr
// -----------------------------------------------------------------------------
module alu16_rq_mem #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointer/count
    // logic in the parent, so resetting storage would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/alu16_result_queue.sv
// -----------------------------------------------------------------------------
// alu16_result_queue
//   Downstream stage of the 16-bit ALU. Captures results under valid/ready,
//   derives zero/negative flags at capture, buffers them in a DEPTH-entry FIFO
//   and presents them in order to the consumer.
//
//   Configuration macro: ALU16_RQ_PARITY_EN (adds out_par, stores parity bit)
//
//   Ports
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous active-high reset
//     in_valid   in   1      ALU result presented
//     in_ready   out  1      queue can accept (!full), 0 while rst is high
//     in_yout    in   16     result word
//     in_carry   in   1      carry / shifted-out bit
//     in_op      in   4      opcode
//     out_valid  out  1      head entry valid
//     out_ready  in   1      consumer accepts head
//     out_data   out  16     head result word
//     out_carry  out  1      head carry
//     out_zero   out  1      head result == 0
//     out_neg    out  1      head result bit 15
//     out_op     out  4      head opcode
//     out_par    out  1      head even parity (only with ALU16_RQ_PARITY_EN)
//     count      out  AW+1   occupied entries, 0..DEPTH
//     drop_err   out  1      sticky: in_valid while !in_ready
//     err_clr    in   1      synchronous clear of drop_err (set wins)
// -----------------------------------------------------------------------------
module alu16_result_queue
    import alu16_result_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_yout,
    input  logic          in_carry,
    input  logic [3:0]    in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic          out_carry,
    output logic          out_zero,
    output logic          out_neg,
    output logic [3:0]    out_op,
`ifdef ALU16_RQ_PARITY_EN
    output logic          out_par,
`endif
    output logic [AW:0]   count,
    output logic          drop_err,
    input  logic          err_clr
);

    localparam int CNT_W = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drop_err_q, drop_err_d;

    logic             full;
    logic             push;
    logic             pop;
    rq_entry_t        wr_entry;
    logic [ENTRY_W-1:0] rd_word;
    rq_entry_t        head;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred. Combinational logic
    // uses blocking '=' throughout.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        // Full refuses input even when the head is leaving: no pass-through.
        in_ready  = !rst && !full;
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_entry  = make_entry(in_yout, in_carry, in_op);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_err_d = drop_err_q;

        // Pointers are exactly AW bits, so +1 wraps modulo DEPTH for free.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // Set has priority over clear so a drop is never silently lost.
        if (in_valid && !in_ready) begin
            drop_err_d = 1'b1;
        end else if (err_clr) begin
            drop_err_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_err_q <= drop_err_d;
        end
    end

    alu16_rq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_word)
    );

    // Storage is not reset, so the head fields are forced to zero while rst
    // is high to keep the outputs defined.
    always_comb begin
        head      = rq_entry_t'(rd_word);
        out_data  = rst ? 16'h0000 : head.yout;
        out_carry = rst ? 1'b0     : head.carry;
        out_zero  = rst ? 1'b0     : head.zero;
        out_neg   = rst ? 1'b0     : head.neg;
        out_op    = rst ? 4'h0     : head.op;
`ifdef ALU16_RQ_PARITY_EN
        out_par   = rst ? 1'b0     : head.par;
`endif
    end

    assign count    = count_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_alu16_result_queue.sv
// -----------------------------------------------------------------------------
// tb_alu16_result_queue
//   Self-checking bench for alu16_result_queue. A queue of expected results
//   models the FIFO; flags are derived from the stored word arithmetically.
// -----------------------------------------------------------------------------
module tb_alu16_result_queue;
    import alu16_result_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_yout;
    logic        in_carry;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;
    logic        out_neg;
    logic [3:0]  out_op;
`ifdef ALU16_RQ_PARITY_EN
    logic        out_par;
`endif
    logic [AW:0] count;
    logic        drop_err;
    logic        err_clr;

    alu16_result_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_yout   (in_yout),
        .in_carry  (in_carry),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_op    (out_op),
`ifdef ALU16_RQ_PARITY_EN
        .out_par   (out_par),
`endif
        .count     (count),
        .drop_err  (drop_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: plain FIFO of what the producer handed over.
    typedef struct {
        logic [15:0] yout;
        logic        carry;
        logic [3:0]  op;
    } model_t;

    model_t mq[$];
    logic   exp_drop;
    bit     last_acc;
    int     n_pass  = 0;
    int     n_total = 0;

    // Advance one clock and update the model from the inputs presented now.
    task automatic step();
        model_t e;
        bit acc, pp, drp;
        e.yout  = in_yout;
        e.carry = in_carry;
        e.op    = in_op;
        acc = (in_valid === 1'b1) && (mq.size() < DEPTH);
        pp  = (out_ready === 1'b1) && (mq.size() > 0);
        drp = (in_valid === 1'b1) && !acc;
        @(posedge clk);
        #1;
        if (pp)  void'(mq.pop_front());
        if (acc) mq.push_back(e);
        if (drp) exp_drop = 1'b1;
        else if (err_clr === 1'b1) exp_drop = 1'b0;
        last_acc = acc;
    endtask

    task automatic drive(input logic v, input logic [15:0] y, input logic c, input logic [3:0] op);
        in_valid = v;
        in_yout  = y;
        in_carry = c;
        in_op    = op;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 4'h0);
        out_ready = 1'b0;
        err_clr   = 1'b0;
        exp_drop  = 1'b0;
        #2;
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        n_total++; if (drop_err !== 1'b0) $display("FAIL reset_drop_err got=%b exp=0", drop_err); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL reset_out_data got=%h exp=0000", out_data); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_first_push();
        drive(1'b1, 16'h0000, 1'b1, ALU_OP_ADD);
        step();
        drive(1'b0, 16'h0, 1'b0, 4'h0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL first_out_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (out_zero !== 1'b1) $display("FAIL first_out_zero got=%b exp=1", out_zero); else n_pass++;
        n_total++; if (out_carry !== 1'b1) $display("FAIL first_out_carry got=%b exp=1", out_carry); else n_pass++;
        n_total++; if (out_neg !== 1'b0) $display("FAIL first_out_neg got=%b exp=0", out_neg); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL first_count got=%0d exp=1", count); else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL first_drain_valid got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_fill_drop();
        logic [15:0] vals [4];
        vals[0] = 16'h0001; vals[1] = 16'h0002; vals[2] = 16'h0003; vals[3] = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], 1'b0, 4'(i));
            step();
        end
        n_total++; if (count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", count); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got=%b exp=0", in_ready); else n_pass++;
        drive(1'b1, 16'h0055, 1'b0, 4'h5);
        step();
        drive(1'b0, 16'h0, 1'b0, 4'h0);
        n_total++; if (drop_err !== 1'b1) $display("FAIL fill_drop_err got=%b exp=1", drop_err); else n_pass++;
        n_total++; if (count !== 3'd4) $display("FAIL fill_drop_count got=%0d exp=4", count); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (out_data !== vals[i]) $display("FAIL fill_pop%0d_data got=%h exp=%h", i, out_data, vals[i]); else n_pass++;
            n_total++;
            if (out_op !== 4'(i)) $display("FAIL fill_pop%0d_op got=%h exp=%h", i, out_op, 4'(i)); else n_pass++;
            if (i == 3) begin
                n_total++; if (out_neg !== 1'b1) $display("FAIL fill_last_neg got=%b exp=1", out_neg); else n_pass++;
            end
            step();
        end
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL fill_empty got=%b exp=0", out_valid); else n_pass++;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_total++; if (drop_err !== 1'b0) $display("FAIL fill_clear got=%b exp=0", drop_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h1000, 1'b0, 4'h1); step();
        drive(1'b1, 16'h1001, 1'b1, 4'h2); step();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'h1002 + 16'(k), 1'(k), 4'(k));
            n_total++;
            if (out_data !== 16'h1000 + 16'(k)) $display("FAIL b2b_order%0d got=%h exp=%h", k, out_data, 16'h1000 + 16'(k)); else n_pass++;
            step();
            n_total++;
            if (count !== 3'd2) $display("FAIL b2b_count%0d got=%0d exp=2", k, count); else n_pass++;
        end
        drive(1'b0, 16'h0, 1'b0, 4'h0);
        n_total++; if (out_data !== 16'h100A) $display("FAIL b2b_tail0 got=%h exp=100a", out_data); else n_pass++;
        step();
        n_total++; if (out_data !== 16'h100B) $display("FAIL b2b_tail1 got=%h exp=100b", out_data); else n_pass++;
        step();
        out_ready = 1'b0;
        n_total++; if (count !== 3'd0) $display("FAIL b2b_drain got=%0d exp=0", count); else n_pass++;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0A00 + 16'(i), 1'b0, ALU_OP_MUL);
            step();
        end
        drive(1'b1, 16'h0BAD, 1'b0, 4'h3);
        out_ready = 1'b1;
        step();
        drive(1'b0, 16'h0, 1'b0, 4'h0);
        out_ready = 1'b0;
        n_total++; if (count !== 3'd3) $display("FAIL full_pop_count got=%0d exp=3", count); else n_pass++;
        n_total++; if (drop_err !== 1'b1) $display("FAIL full_pop_drop got=%b exp=1", drop_err); else n_pass++;
        n_total++; if (out_data !== 16'h0A01) $display("FAIL full_pop_head got=%h exp=0a01", out_data); else n_pass++;
        n_total++; if (out_op !== ALU_OP_MUL) $display("FAIL full_pop_op got=%h exp=f", out_op); else n_pass++;
    endtask

    task automatic test_err_clr();
        drive(1'b1, 16'h0C00, 1'b0, 4'h0);
        step();
        n_total++; if (count !== 3'd4) $display("FAIL errclr_refill got=%0d exp=4", count); else n_pass++;
        drive(1'b1, 16'h0C01, 1'b0, 4'h0);
        err_clr = 1'b1;
        step();
        n_total++; if (drop_err !== 1'b1) $display("FAIL errclr_set_wins got=%b exp=1", drop_err); else n_pass++;
        drive(1'b0, 16'h0, 1'b0, 4'h0);
        step();
        err_clr = 1'b0;
        n_total++; if (drop_err !== 1'b0) $display("FAIL errclr_clear got=%b exp=0", drop_err); else n_pass++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_total++; if (count !== 3'd3) $display("FAIL areset_pre_count got=%0d exp=3", count); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (count !== 3'd0) $display("FAIL areset_count got=%0d exp=0", count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL areset_in_ready got=%b exp=0", in_ready); else n_pass++;
        mq.delete();
        exp_drop = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL areset_release_ready got=%b exp=1", in_ready); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL areset_release_count got=%0d exp=0", count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL areset_release_valid got=%b exp=0", out_valid); else n_pass++;
`ifdef ALU16_RQ_PARITY_EN
        drive(1'b1, 16'h0007, 1'b0, 4'h0);
        step();
        drive(1'b0, 16'h0, 1'b0, 4'h0);
        n_total++; if (out_par !== 1'b1) $display("FAIL parity_0007 got=%b exp=1", out_par); else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif
    endtask

    task automatic test_random();
        last_acc = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            // Producer holds a pending item until it is accepted.
            if (!in_valid || last_acc) begin
                drive(($urandom_range(0, 9) < 7), 16'($urandom), 1'($urandom), 4'($urandom));
                if ($urandom_range(0, 7) == 0) in_yout = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'h8000;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            err_clr   = ($urandom_range(0, 9) == 0);
            step();
            n_total++;
            if (count !== 3'(mq.size())) $display("FAIL rnd%0d_count got=%0d exp=%0d", cyc, count, mq.size()); else n_pass++;
            n_total++;
            if (in_ready !== (mq.size() < DEPTH)) $display("FAIL rnd%0d_in_ready got=%b exp=%b", cyc, in_ready, mq.size() < DEPTH); else n_pass++;
            n_total++;
            if (drop_err !== exp_drop) $display("FAIL rnd%0d_drop_err got=%b exp=%b", cyc, drop_err, exp_drop); else n_pass++;
            n_total++;
            if (out_valid !== (mq.size() != 0)) $display("FAIL rnd%0d_out_valid got=%b exp=%b", cyc, out_valid, mq.size() != 0); else n_pass++;
            if (mq.size() != 0) begin
                n_total++;
                if (out_data !== mq[0].yout || out_carry !== mq[0].carry || out_op !== mq[0].op ||
                    out_zero !== (mq[0].yout == 16'd0) || out_neg !== (mq[0].yout >= 16'h8000))
                    $display("FAIL rnd%0d_head got=%h/%b/%h/z%b/n%b exp=%h/%b/%h/z%b/n%b", cyc,
                             out_data, out_carry, out_op, out_zero, out_neg,
                             mq[0].yout, mq[0].carry, mq[0].op, mq[0].yout == 16'd0, mq[0].yout >= 16'h8000);
                else n_pass++;
`ifdef ALU16_RQ_PARITY_EN
                n_total++;
                if (out_par !== 1'($countones(mq[0].yout) % 2))
                    $display("FAIL rnd%0d_par got=%b exp=%b", cyc, out_par, $countones(mq[0].yout) % 2);
                else n_pass++;
`endif
            end
        end
        drive(1'b0, 16'h0, 1'b0, 4'h0);
        err_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH) step();
        out_ready = 1'b0;
        n_total++; if (count !== 3'd0) $display("FAIL rnd_drain got=%0d exp=0", count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill_drop();
        test_back_to_back();
        test_full_pop();
        test_err_clr();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
